// File: rtl/sc_stream_decoder.sv
// rtl/sc_stream_decoder.sv - counts ones over a 2^WIDTH-bit window of a stochastic stream
module sc_stream_decoder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             bit_in,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_count
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   // Sample index of the final bit of a window (2^WIDTH - 1).
   localparam logic [WIDTH:0] LAST_SAMPLE = {1'b0, {WIDTH{1'b1}}};

   state_t         state_q, state_d;
   logic [WIDTH:0] samples_q, samples_d;
   logic [WIDTH:0] ones_q, ones_d;
   logic [WIDTH:0] count_q, count_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         samples_q <= '0;
         ones_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         samples_q <= samples_d;
         ones_q    <= ones_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      samples_d = samples_q;
      ones_d    = ones_q;
      count_d   = count_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_ACCUM;
               samples_d = '0;
               ones_d    = '0;
            end
         end
         S_ACCUM: begin
            // bit_in is only looked at when in_valid is set, so X on idle cycles cannot leak in.
            if (in_valid) begin
               samples_d = samples_q + 1'b1;
               ones_d    = ones_q + {{WIDTH{1'b0}}, bit_in};
               if (samples_q == LAST_SAMPLE) begin
                  state_d = S_DONE;
                  count_d = ones_d;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               if (start) begin
                  state_d   = S_ACCUM;
                  samples_d = '0;
                  ones_d    = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == S_ACCUM);
      out_valid = (state_q == S_DONE);
      out_count = count_q;
   end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb/tb_sc_stream_decoder.sv - randomized self-checking bench for sc_stream_decoder
module tb_sc_stream_decoder;

   localparam int W = 4;
   localparam int N = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic         bit_in = 1'b0;
   logic         out_ready = 1'b0;
   logic         busy;
   logic         out_valid;
   logic [W:0]   out_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sc_stream_decoder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .bit_in    (bit_in),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int popcount(input bit q[$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s;
   endfunction

   // Start from IDLE; a valid one is presented on the start cycle and must be dropped.
   task automatic begin_window();
      start = 1'b1;
      in_valid = 1'b1;
      bit_in = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b0;
   endtask

   // Presents every bit of q, inserting exactly 'gaps' in_valid=0 cycles before the last bit.
   // 'early' counts cycles before the final bit where the decoder was not busy or already done.
   task automatic feed(input bit q[$], input int gaps, output int early, output int cyc);
      int idx = 0;
      int g = gaps;
      early = 0;
      cyc = 0;
      while (idx < q.size()) begin
         if (out_valid || !busy) early++;
         if (g > 0 && (($urandom_range(0, 1) == 1) || g >= q.size() - idx)) begin
            in_valid = 1'b0;
            bit_in = 1'bx;
            g--;
         end else begin
            in_valid = 1'b1;
            bit_in = q[idx];
            idx++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      bit_in = 1'b0;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_count !== '0) begin
         fails++;
         $display("FAIL reset: busy=%b out_valid=%b out_count=%0d, want 0/0/0", busy, out_valid, out_count);
      end
      in_valid = 1'b1;
      bit_in = 1'b1;
      repeat (20) tick();
      in_valid = 1'b0;
      tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL idle_ignores_bits: busy=%b out_valid=%b, want 0/0", busy, out_valid);
      end
   endtask

   task automatic run_constant(input bit val, input string name);
      bit q[$];
      int early, cyc, exp_n;
      for (int i = 0; i < N; i++) q.push_back(val);
      exp_n = popcount(q);
      begin_window();
      tests++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL %s_start: busy=%b out_valid=%b, want 1/0", name, busy, out_valid);
      end
      feed(q, 0, early, cyc);
      tests++;
      if (early !== 0) begin
         fails++;
         $display("FAIL %s_window_length: %0d bad cycles before last bit, want 0", name, early);
      end
      tests++;
      if (out_valid !== 1'b1 || busy !== 1'b0 || out_count !== (W+1)'(exp_n)) begin
         fails++;
         $display("FAIL %s_result: out_valid=%b busy=%b out_count=%0d, want 1/0/%0d",
                  name, out_valid, busy, out_count, exp_n);
      end
      accept();
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_count !== (W+1)'(exp_n)) begin
         fails++;
         $display("FAIL %s_accept: out_valid=%b busy=%b out_count=%0d, want 0/0/%0d",
                  name, out_valid, busy, out_count, exp_n);
      end
   endtask

   task automatic test_zeros();
      run_constant(1'b0, "zeros");
   endtask

   task automatic test_ones();
      run_constant(1'b1, "ones");
   endtask

   task automatic test_alternating();
      bit q[$];
      int early, cyc;
      for (int i = 0; i < N; i++) q.push_back(bit'(~i[0]));
      begin_window();
      feed(q, 5, early, cyc);
      tests++;
      if (early !== 0) begin
         fails++;
         $display("FAIL alt_early_valid: %0d bad cycles within %0d-cycle window, want 0", early, cyc);
      end
      tests++;
      if (out_valid !== 1'b1 || out_count !== (W+1)'(8)) begin
         fails++;
         $display("FAIL alt_result: out_valid=%b out_count=%0d, want 1/8", out_valid, out_count);
      end
      accept();
   endtask

   task automatic test_back_to_back();
      bit q[$];
      bit t;
      int early, cyc, exp_n, j;
      int bad = 0;
      for (int i = 0; i < N; i++) q.push_back(1'($urandom_range(0, 1)));
      exp_n = popcount(q);
      begin_window();
      feed(q, 2, early, cyc);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         bit_in = 1'($urandom_range(0, 1));
         tick();
         if (out_valid !== 1'b1 || busy !== 1'b0 || out_count !== (W+1)'(exp_n)) bad++;
      end
      in_valid = 1'b0;
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL hold_in_done: %0d cycles lost result, out_count=%0d want %0d", bad, out_count, exp_n);
      end
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      out_ready = 1'b0;
      start = 1'b0;
      tests++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || out_count !== (W+1)'(exp_n)) begin
         fails++;
         $display("FAIL b2b_restart: busy=%b out_valid=%b out_count=%0d, want 1/0/%0d",
                  busy, out_valid, out_count, exp_n);
      end
      q.delete();
      for (int i = 0; i < N; i++) q.push_back(i < 12);
      for (int i = 0; i < N; i++) begin
         j = $urandom_range(0, N - 1);
         t = q[i];
         q[i] = q[j];
         q[j] = t;
      end
      feed(q, 3, early, cyc);
      tests++;
      if (early !== 0 || out_valid !== 1'b1 || out_count !== (W+1)'(12)) begin
         fails++;
         $display("FAIL b2b_second: early=%0d out_valid=%b out_count=%0d, want 0/1/12", early, out_valid, out_count);
      end
      accept();
      tests++;
      if (out_count !== (W+1)'(12) || busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_holds_count: out_count=%0d busy=%b, want 12/0", out_count, busy);
      end
   endtask

   task automatic test_mid_reset();
      bit q[$];
      int early, cyc;
      for (int i = 0; i < 7; i++) q.push_back(1'b1);
      begin_window();
      feed(q, 1, early, cyc);
      rst = 1'b1;
      in_valid = 1'b1;
      bit_in = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_count !== '0) begin
         fails++;
         $display("FAIL mid_reset: busy=%b out_valid=%b out_count=%0d, want 0/0/0", busy, out_valid, out_count);
      end
      q.delete();
      for (int i = 0; i < N; i++) q.push_back(i == 2 || i == 9 || i == 15);
      begin_window();
      feed(q, 0, early, cyc);
      tests++;
      if (early !== 0 || out_valid !== 1'b1 || out_count !== (W+1)'(3)) begin
         fails++;
         $display("FAIL post_reset_window: early=%0d out_valid=%b out_count=%0d, want 0/1/3", early, out_valid, out_count);
      end
      accept();
   endtask

   task automatic test_start_ignored();
      bit q[$];
      bit a[$];
      bit b[$];
      bit c[$];
      int e1, e2, e3, cyc, exp_n;
      for (int i = 0; i < N; i++) q.push_back(1'($urandom_range(0, 1)));
      exp_n = popcount(q);
      for (int i = 0; i < N; i++) begin
         if (i < 4) a.push_back(q[i]);
         else if (i == 4) b.push_back(q[i]);
         else c.push_back(q[i]);
      end
      begin_window();
      feed(a, 1, e1, cyc);
      start = 1'b1;
      feed(b, 0, e2, cyc);
      start = 1'b0;
      feed(c, 2, e3, cyc);
      tests++;
      if (e1 + e2 + e3 !== 0 || out_valid !== 1'b1 || out_count !== (W+1)'(exp_n)) begin
         fails++;
         $display("FAIL start_in_accum: early=%0d out_valid=%b out_count=%0d, want 0/1/%0d",
                  e1 + e2 + e3, out_valid, out_count, exp_n);
      end
      accept();
   endtask

   task automatic test_random();
      bit q[$];
      int early, cyc, exp_n, bad;
      bit chained = 1'b0;
      for (int w = 0; w < 10; w++) begin
         q.delete();
         for (int i = 0; i < N; i++) q.push_back(1'($urandom_range(0, 1)));
         exp_n = popcount(q);
         if (!chained) begin_window();
         feed(q, $urandom_range(0, 6), early, cyc);
         bad = 0;
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'($urandom_range(0, 1));
            bit_in = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            tick();
            if (out_valid !== 1'b1 || out_count !== (W+1)'(exp_n)) bad++;
         end
         in_valid = 1'b0;
         tests++;
         if (early !== 0 || bad !== 0 || out_valid !== 1'b1 || out_count !== (W+1)'(exp_n)) begin
            fails++;
            $display("FAIL random_window_%0d: early=%0d hold_bad=%0d out_valid=%b out_count=%0d, want 0/0/1/%0d",
                     w, early, bad, out_valid, out_count, exp_n);
         end
         chained = 1'($urandom_range(0, 1));
         out_ready = 1'b1;
         start = chained;
         tick();
         out_ready = 1'b0;
         start = 1'b0;
         tests++;
         if (busy !== chained || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL random_accept_%0d: busy=%b out_valid=%b, want %b/0", w, busy, out_valid, chained);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zeros();
      test_ones();
      test_alternating();
      test_back_to_back();
      test_mid_reset();
      test_start_ignored();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
